// File: rtl/mcdp_pkg.sv
// Shared types and encodings for the multicycle 8-bit datapath.
// Opcode/funct constants and the controller state enum live here.
package mcdp_pkg;

    typedef enum logic [2:0] {
        S_FETCH0,
        S_FETCH1,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;

    function automatic logic insn_legal(input logic [3:0] op, input logic [2:0] funct);
        case (op)
            OP_R:    return funct inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT};
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcdp_regfile.sv
// Register file: NREGS x DWIDTH, two async read ports, one write port.
// r0 always reads zero and ignores writes.
module mcdp_regfile #(
    parameter int          DWIDTH = 8,
    parameter int unsigned NREGS  = 4,
    localparam int         RAW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RAW-1:0]    ra1,
    input  logic [RAW-1:0]    ra2,
    output logic [DWIDTH-1:0] rd1,
    output logic [DWIDTH-1:0] rd2,
    input  logic              we,
    input  logic [RAW-1:0]    wa,
    input  logic [DWIDTH-1:0] wd
);

    logic [DWIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle 8-bit core: 16-bit instructions fetched as two bytes over one
// shared memory port with a ready handshake; controller FSM is inline.
module multicycle_datapath
    import mcdp_pkg::*;
#(
    parameter int          DWIDTH   = 8,
    parameter int          IWIDTH   = 16,
    parameter int unsigned NREGS    = 4,
    parameter int          RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DWIDTH-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    localparam int RAW  = $clog2(NREGS);
    localparam int IMMW = IWIDTH - 4 - 2*RAW;
    localparam int JW   = IWIDTH - 4;

    state_t state, next_state;

    logic [IWIDTH-1:0] ir;
    logic [DWIDTH-1:0] a, b, aluout, mdr, alu_res;
    logic [DWIDTH-1:0] rf_rd1, rf_rd2, rf_wd;
    logic [RAW-1:0]    rf_wa;
    logic              rf_we;

    logic [3:0]        op;
    logic [RAW-1:0]    rs, rt, rd;
    logic [IMMW-1:0]   imm;
    logic [2:0]        funct;
    logic [DWIDTH-1:0] simm, jaddr;
    logic              legal;

    assign op    = ir[IWIDTH-1 -: 4];
    assign rs    = ir[IWIDTH-5 -: RAW];
    assign rt    = ir[IWIDTH-5-RAW -: RAW];
    assign rd    = ir[IWIDTH-5-2*RAW -: RAW];
    assign imm   = ir[IMMW-1:0];
    assign funct = ir[2:0];
    assign simm  = DWIDTH'($signed(imm));
    assign jaddr = DWIDTH'(ir[JW-1:0]);
    assign legal = insn_legal(op, funct);

    mcdp_regfile #(.DWIDTH(DWIDTH), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    assign rf_we = (state == S_WB);
    assign rf_wa = (op == OP_R) ? rd : rt;
    assign rf_wd = (op == OP_LW) ? mdr : aluout;

    always_comb begin
        alu_res = a + simm;
        if (op == OP_R) begin
            case (funct)
                F_AND:   alu_res = a & b;
                F_OR:    alu_res = a | b;
                F_SUB:   alu_res = a - b;
                F_SLT:   alu_res = DWIDTH'($signed(a) < $signed(b));
                default: alu_res = a + b;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH0;
            pc      <= DWIDTH'(RESET_PC);
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            aluout  <= '0;
            mdr     <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_FETCH0: if (mem_ready) ir[DWIDTH-1:0] <= mem_rdata;
                S_FETCH1: begin
                    if (mem_ready) begin
                        ir[IWIDTH-1 -: DWIDTH] <= mem_rdata;
                        pc <= pc + DWIDTH'(2);
                    end
                end
                S_DECODE: begin
                    a <= rf_rd1;
                    b <= rf_rd2;
                    if (op == OP_J) begin
                        pc <= jaddr;
                    end else if (op == OP_HALT || !legal) begin
                        halted  <= 1'b1;
                        illegal <= !legal;
                    end
                end
                S_EXEC: begin
                    aluout <= alu_res;
                    // pc already points past this instruction here
                    if (op == OP_BEQ && a == b) pc <= pc + (simm << 1);
                end
                S_MEM: if (mem_ready && op == OP_LW) mdr <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Reset gates the bus combinationally so a pending request drops at once.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (reset) begin
            case (state)
                S_FETCH0: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                    if (mem_ready) next_state = S_FETCH1;
                end
                S_FETCH1: begin
                    mem_req  = 1'b1;
                    mem_addr = pc + DWIDTH'(1);
                    if (mem_ready) next_state = S_DECODE;
                end
                S_DECODE: begin
                    if (op == OP_J)                      next_state = S_FETCH0;
                    else if (op == OP_HALT || !legal)    next_state = S_HALT;
                    else                                 next_state = S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_BEQ)                    next_state = S_FETCH0;
                    else if (op == OP_LW || op == OP_SW) next_state = S_MEM;
                    else                                 next_state = S_WB;
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = aluout;
                    if (op == OP_SW) begin
                        mem_we    = 1'b1;
                        mem_wdata = b;
                    end
                    if (mem_ready) next_state = (op == OP_LW) ? S_WB : S_FETCH0;
                end
                S_WB:    next_state = S_FETCH0;
                default: next_state = S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: small programs in a byte memory
// model with programmable wait states; results observed on the bus and outputs.
module tb_multicycle_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mem_req, mem_we, mem_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic       halted, illegal;

    always #5 clk = ~clk;

    multicycle_datapath #(
        .DWIDTH   (8),
        .IWIDTH   (16),
        .NREGS    (4),
        .RESET_PC (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Memory model: addresses 0x40-0x7F are the data region with their own wait count.
    logic [7:0] mem [256];
    int fetch_wait = 0;
    int data_wait  = 0;
    int wcnt       = 0;
    int cur_wait;

    assign cur_wait  = (mem_addr >= 8'h40 && mem_addr < 8'h80) ? data_wait : fetch_wait;
    assign mem_ready = mem_req && (wcnt >= cur_wait);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    // Per-cycle bus trace, index 0 = first cycle after reset release.
    logic       tr_req [512];
    logic       tr_we  [512];
    logic [7:0] tr_addr[512];
    logic [7:0] tr_pc  [512];
    int         cyc = 0;
    bit         tracing = 1'b0;

    always @(negedge clk) begin
        if (tracing && cyc < 512) begin
            tr_req[cyc]  <= mem_req;
            tr_we[cyc]   <= mem_we;
            tr_addr[cyc] <= mem_addr;
            tr_pc[cyc]   <= pc;
            cyc <= cyc + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_fetch(input logic [7:0] addr, input int from);
        for (int i = from; i < cyc; i++)
            if (tr_req[i] && !tr_we[i] && tr_addr[i] == addr) return i;
        return -1;
    endfunction

    function automatic int count_writes(input logic [7:0] addr);
        int n = 0;
        for (int i = 0; i < cyc; i++)
            if (tr_req[i] && tr_we[i] && tr_addr[i] == addr) n++;
        return n;
    endfunction

    task automatic boot();
        reset   = 1'b0;
        tracing = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 256; i++) mem[i] = (i >= 64 && i < 128) ? 8'hAA : 8'h00;
        fetch_wait = 0;
        data_wait  = 0;
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] insn);
        logic [7:0] a1;
        a1 = addr + 8'd1;
        mem[addr] = insn[7:0];
        mem[a1]   = insn[15:8];
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        cyc     = 0;
        tracing = 1'b1;
    endtask

    task automatic run(input string tag, input int maxc);
        int k = 0;
        while (!halted && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(tag, halted, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, k;
        logic seen_req;

        // Reset state
        boot();
        repeat (2) @(negedge clk);
        check("rst_req",   mem_req,   0);
        check("rst_we",    mem_we,    0);
        check("rst_addr",  mem_addr,  0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_pc",    pc,        0);
        check("rst_halt",  {halted, illegal}, 0);

        // Zero-wait ADDI, SW, HALT
        load(8'h00, 16'h4105);
        load(8'h02, 16'h2140);
        load(8'h04, 16'hF000);
        release_reset();
        run("t1_halt", 60);
        check("t1_c0",       {tr_req[0], tr_addr[0]}, {1'b1, 8'h00});
        check("t1_c1",       {tr_req[1], tr_addr[1]}, {1'b1, 8'h01});
        check("t1_idle",     {tr_req[2], tr_req[3], tr_req[4]}, 0);
        check("t1_next_req", first_fetch(8'h02, 0), 5);
        check("t1_pc5",      tr_pc[5], 8'h02);
        check("t1_r1",       mem[8'h40], 8'h05);
        check("t1_illegal",  illegal, 0);
        check("t1_pc_end",   pc, 8'h06);

        // SUB / SLT / r0 discard
        boot();
        load(8'h00, 16'h4103);
        load(8'h02, 16'h4305);
        load(8'h04, 16'h0786);
        load(8'h06, 16'h2241);
        load(8'h08, 16'h0787);
        load(8'h0A, 16'h2242);
        load(8'h0C, 16'h4007);
        load(8'h0E, 16'h2043);
        load(8'h10, 16'hF000);
        release_reset();
        run("t2_halt", 120);
        check("t2_sub", mem[8'h41], 8'hFE);
        check("t2_slt", mem[8'h42], 8'h01);
        check("t2_r0",  mem[8'h43], 8'h00);

        // SW then LW with 2 data wait cycles
        boot();
        data_wait = 2;
        load(8'h00, 16'h4105);
        load(8'h02, 16'h2140);
        load(8'h04, 16'h1240);
        load(8'h06, 16'h2244);
        load(8'h08, 16'hF000);
        release_reset();
        run("t3_halt", 120);
        check("t3_sw_hold", count_writes(8'h40), 3);
        check("t3_sw_data", mem[8'h40], 8'h05);
        check("t3_sw_lat",  first_fetch(8'h04, 0) - first_fetch(8'h02, 0), 7);
        check("t3_lw_lat",  first_fetch(8'h06, 0) - first_fetch(8'h04, 0), 8);
        check("t3_lw_val",  mem[8'h44], 8'h05);

        // BEQ taken backwards
        boot();
        load(8'h00, 16'h5010);
        load(8'h10, 16'h30FE);
        load(8'h0E, 16'hF000);
        release_reset();
        run("t4_halt", 60);
        t = first_fetch(8'h10, 0);
        check("t4_j_lat",   t, 3);
        check("t4_beq_pc",  tr_pc[t+4], 8'h0E);
        check("t4_beq_lat", first_fetch(8'h0E, t) - t, 4);
        check("t4_pc_end",  pc, 8'h10);

        // BEQ not taken, then J to 0xA3
        boot();
        load(8'h00, 16'h4105);
        load(8'h02, 16'h5010);
        load(8'h10, 16'h34FE);
        load(8'h12, 16'h50A3);
        load(8'hA3, 16'hF000);
        release_reset();
        run("t5_halt", 80);
        t = first_fetch(8'h10, 0);
        check("t5_nt_pc",  tr_pc[t+4], 8'h12);
        check("t5_nt_lat", first_fetch(8'h12, t) - t, 4);
        t2 = first_fetch(8'h12, t);
        check("t5_j_pc",   tr_pc[t2+3], 8'hA3);
        check("t5_j_tgt",  first_fetch(8'hA3, t2) - t2, 3);
        check("t5_pc_end", pc, 8'hA5);

        // Illegal opcode
        boot();
        load(8'h00, 16'h7000);
        release_reset();
        run("t6_halt", 40);
        check("t6_illegal", illegal, 1);
        seen_req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_req = seen_req | mem_req;
        end
        check("t6_no_req", seen_req, 0);

        // Illegal R-type funct
        boot();
        load(8'h00, 16'h0003);
        release_reset();
        run("t7_halt", 40);
        check("t7_illegal", illegal, 1);

        // PC wrap: fetch at FF reads FF then 00
        boot();
        load(8'h00, 16'h50FF);
        mem[8'hFF] = 8'h00;
        release_reset();
        run("t8_halt", 40);
        t = first_fetch(8'hFF, 0);
        check("t8_ff",      t, 3);
        check("t8_wrap",    {tr_req[t+1], tr_addr[t+1]}, {1'b1, 8'h00});
        check("t8_illegal", illegal, 0);
        check("t8_pc",      pc, 8'h01);

        // Reset during a FETCH1 wait
        boot();
        fetch_wait = 3;
        load(8'h00, 16'h4105);
        load(8'h02, 16'hF000);
        release_reset();
        k = 0;
        while (!(mem_req && mem_addr == 8'h01) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t9_in_f1", {mem_req, mem_addr}, {1'b1, 8'h01});
        reset = 1'b0;
        #1;
        check("t9_req_drop", mem_req, 0);
        check("t9_addr_clr", mem_addr, 0);
        tracing = 1'b0;
        @(negedge clk);
        release_reset();
        run("t9_halt", 100);
        check("t9_restart", {tr_req[0], tr_addr[0]}, {1'b1, 8'h00});
        check("t9_f1_wait", first_fetch(8'h01, 0), 4);
        check("t9_pc_end",  pc, 8'h04);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
